// File: rtl/ml_pkg.sv
// Shared constants and FSM state type for the ML hard-bit collector.
// No logic; compile before any module that imports it.
// Group geometry is fixed at 8 samples; LLR width is overridable per instance.
package ml_pkg;

  localparam int ML_GRP_BITS = 8;
  localparam int ML_LLR_W    = 8;
  localparam int ML_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ml_state_t;

endpackage

// File: rtl/ml_grp_fifo.sv
// Generic group FIFO with registered storage and head-of-queue read port.
// Latency: a written word is visible at the head one cycle after its write edge.
// Backpressure: writes are dropped when full and reads ignored when empty; callers gate on flags.
module ml_grp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wr_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_rd_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indexes match
  assign o_empty  = (wr_ptr == rd_ptr);
  assign o_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_rd_dat = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads zero out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        mem[wr_ptr[AW-1:0]] <= i_wr_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ml_hb_collector.sv
// Collects 8 serial demodulator results into one hard-bit/LLR group and queues groups per frame.
// Latency: a group appears on o_grp_vld one cycle after the edge that accepted its 8th sample.
// Backpressure: o_rd_rdy drops only when the 8th sample would hit a full FIFO (registered terms only).
module ml_hb_collector
  import ml_pkg::*;
#(
  parameter int LLR_W   = ML_LLR_W,
  parameter int DEPTH   = 4,
  parameter int NUM_GRP = 1000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_rd_vld,
  input  logic [LLR_W-1:0]               i_llr,
  input  logic                           i_hard_bit,
  output logic                           o_rd_rdy,
  output logic                           o_grp_vld,
  input  logic                           i_grp_rdy,
  output logic [ML_GRP_BITS-1:0]         o_hb_byte,
  output logic [ML_GRP_BITS*LLR_W-1:0]   o_llr_vec,
  output logic [ML_CNT_W-1:0]            o_grp_cnt,
  output logic                           o_frame_done
);

  localparam int W = ML_GRP_BITS + ML_GRP_BITS*LLR_W;
  localparam logic [ML_CNT_W-1:0] GRP_LIM  = ML_CNT_W'(NUM_GRP);
  localparam logic [ML_CNT_W-1:0] GRP_LAST = ML_CNT_W'(NUM_GRP - 1);

  ml_state_t                       state;
  logic [2:0]                      bcnt;
  logic [ML_CNT_W-1:0]             grp_in;
  logic [ML_GRP_BITS-1:0]          hb_asm;
  logic [ML_GRP_BITS*LLR_W-1:0]    llr_asm;
  logic [ML_GRP_BITS-1:0]          hb_nxt;
  logic [ML_GRP_BITS*LLR_W-1:0]    llr_nxt;
  logic [W-1:0]                    wr_dat;
  logic [W-1:0]                    rd_dat;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            acc;
  logic                            push;
  logic                            pop;

  // Ready depends on registers only, so the 8th-sample push never races a pop into a full FIFO
  assign o_rd_rdy  = (state == RUN) && (grp_in < GRP_LIM) && !((bcnt == 3'd7) && fifo_full);
  assign acc       = i_rd_vld && o_rd_rdy;
  assign push      = acc && (bcnt == 3'd7);
  assign o_grp_vld = !fifo_empty;
  assign pop       = o_grp_vld && i_grp_rdy;

  // Merge the incoming sample into its slot so the completed group can be pushed on the same edge
  always_comb begin
    hb_nxt                          = hb_asm;
    llr_nxt                         = llr_asm;
    hb_nxt[bcnt]                    = i_hard_bit;
    llr_nxt[bcnt*LLR_W +: LLR_W]    = i_llr;
  end

  assign wr_dat    = {llr_nxt, hb_nxt};
  assign o_hb_byte = rd_dat[ML_GRP_BITS-1:0];
  assign o_llr_vec = rd_dat[W-1:ML_GRP_BITS];

  // Latch each accepted sample into the assembly registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hb_asm  <= '0;
      llr_asm <= '0;
    end else if (acc) begin
      hb_asm  <= hb_nxt;
      llr_asm <= llr_nxt;
    end
  end

  // Frame FSM with slot counter, pushed/popped group counters and the frame-done pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      bcnt         <= '0;
      grp_in       <= '0;
      o_grp_cnt    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (acc)  bcnt      <= bcnt + 3'd1;
      if (push) grp_in    <= grp_in + ML_CNT_W'(1);
      if (pop)  o_grp_cnt <= o_grp_cnt + ML_CNT_W'(1);
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= RUN;
            bcnt      <= '0;
            grp_in    <= '0;
            o_grp_cnt <= '0;
          end
        end
        RUN: begin
          if (pop && (o_grp_cnt == GRP_LAST)) begin
            state        <= DONE;
            o_frame_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ml_grp_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (push),
    .i_wr_dat (wr_dat),
    .i_pop    (pop),
    .o_rd_dat (rd_dat),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

endmodule

// File: tb/tb_ml_hb_collector.sv
// Scoreboard bench for ml_hb_collector: two instances (long frame and 3-group frame).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected groups are queued at stimulus time and popped by a monitor on each output handshake.
module tb_ml_hb_collector;

  typedef struct packed {
    logic [7:0]  hb;
    logic [63:0] llr;
  } grp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 0, a_rd_vld = 0, a_hard_bit = 0, a_grp_rdy = 0;
  logic [7:0]  a_llr = 0;
  logic        a_rd_rdy, a_grp_vld, a_frame_done;
  logic [7:0]  a_hb_byte;
  logic [63:0] a_llr_vec;
  logic [15:0] a_grp_cnt;

  logic        b_start = 0, b_rd_vld = 0, b_hard_bit = 0, b_grp_rdy = 0;
  logic [7:0]  b_llr = 0;
  logic        b_rd_rdy, b_grp_vld, b_frame_done;
  logic [7:0]  b_hb_byte;
  logic [63:0] b_llr_vec;
  logic [15:0] b_grp_cnt;

  ml_hb_collector #(.LLR_W(8), .DEPTH(4), .NUM_GRP(1000)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_rd_vld(a_rd_vld),
    .i_llr(a_llr), .i_hard_bit(a_hard_bit), .o_rd_rdy(a_rd_rdy),
    .o_grp_vld(a_grp_vld), .i_grp_rdy(a_grp_rdy), .o_hb_byte(a_hb_byte),
    .o_llr_vec(a_llr_vec), .o_grp_cnt(a_grp_cnt), .o_frame_done(a_frame_done)
  );

  ml_hb_collector #(.LLR_W(8), .DEPTH(4), .NUM_GRP(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_rd_vld(b_rd_vld),
    .i_llr(b_llr), .i_hard_bit(b_hard_bit), .o_rd_rdy(b_rd_rdy),
    .o_grp_vld(b_grp_vld), .i_grp_rdy(b_grp_rdy), .o_hb_byte(b_hb_byte),
    .o_llr_vec(b_llr_vec), .o_grp_cnt(b_grp_cnt), .o_frame_done(b_frame_done)
  );

  grp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pops = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  bit   hung = 0;
  bit   stress_on = 0;
  logic [7:0] b_bytes [3] = '{8'hA5, 8'h3C, 8'hF0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic t3hb(input int n);
    int v;
    v = n ^ (n >> 2);
    return v[0];
  endfunction

  function automatic logic [7:0] t3llr(input int n);
    int v;
    v = n * 7 + 3;
    return v[7:0];
  endfunction

  // Scoreboard monitor for dut_a plus accept/frame-done counters
  task automatic monitor();
    grp_t e;
    forever begin
      @(negedge clk);
      if (a_rd_vld && a_rd_rdy) acc_cnt++;
      if (a_frame_done) done_cnt++;
      if (a_grp_vld && a_grp_rdy) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL grp_unexpected: got hb 0x%0h, expected no group", a_hb_byte);
        end else begin
          e = exp_q.pop_front();
          chk("grp_hb", 64'(a_hb_byte), 64'(e.hb));
          chk("grp_llr", a_llr_vec, e.llr);
        end
      end
    end
  endtask

  // Present one sample to dut_a and hold it until accepted; leaves i_rd_vld high
  task automatic send(input logic hb, input logic [7:0] llr);
    bit ok = 0;
    if (hung) return;
    a_rd_vld = 1'b1;
    a_hard_bit = hb;
    a_llr = llr;
    for (int t = 0; t < 4000 && !ok; t++) begin
      @(negedge clk);
      ok = a_rd_rdy;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      hung = 1;
      $display("FAIL send_timeout: got no accept in 4000 cycles, expected accept");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    a_start = 0; a_rd_vld = 0; a_grp_rdy = 0;
    b_start = 0; b_rd_vld = 0; b_grp_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    exp_q.delete();
  endtask

  task automatic start_a();
    a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
  endtask

  initial begin
    grp_t g;
    int   abase, pbase, dbase, k;
    logic [7:0] hb;
    logic [63:0] lv;

    fork
      monitor();
    join_none

    // Reset with valid asserted: nothing accepted, all outputs zero
    a_rd_vld = 1; b_rd_vld = 1;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_rd_rdy", 64'(a_rd_rdy), 64'd0);
    chk("rst_grp_vld", 64'(a_grp_vld), 64'd0);
    chk("rst_frame_done", 64'(a_frame_done), 64'd0);
    chk("rst_grp_cnt", 64'(a_grp_cnt), 64'd0);
    chk("rst_hb_byte", 64'(a_hb_byte), 64'd0);
    chk("rst_llr_vec", a_llr_vec, 64'd0);
    chk("rst_b_rd_rdy", 64'(b_rd_rdy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_rd_rdy", 64'(a_rd_rdy), 64'd0);
    @(posedge clk); #1;
    a_rd_vld = 0; b_rd_vld = 0;
    chk("idle_no_accept", 64'(acc_cnt), 64'd0);

    // Single group 1,0,1,1,0,0,1,0 with LLRs 1..8
    a_grp_rdy = 1;
    start_a();
    hb = 8'h4D;
    lv = '0;
    for (int i = 0; i < 8; i++) lv[i*8 +: 8] = 8'(i + 1);
    g.hb = hb; g.llr = lv;
    exp_q.push_back(g);
    for (int i = 0; i < 7; i++) send(hb[i], 8'(i + 1));
    a_rd_vld = 0;
    @(negedge clk);
    chk("lat_before", 64'(a_grp_vld), 64'd0);
    @(posedge clk); #1;
    send(hb[7], 8'd8);
    a_rd_vld = 0;
    @(negedge clk);
    chk("lat_vld", 64'(a_grp_vld), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_drained", 64'(a_grp_vld), 64'd0);
    chk("single_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 39 accepts then stall with the 8th slot pending
    do_reset();
    start_a();
    abase = acc_cnt;
    pbase = pops;
    for (int gi = 0; gi < 5; gi++) begin
      for (int j = 0; j < 8; j++) begin
        g.hb[j] = t3hb(gi*8 + j);
        g.llr[j*8 +: 8] = t3llr(gi*8 + j);
      end
      exp_q.push_back(g);
    end
    for (int n = 0; n < 39; n++) send(t3hb(n), t3llr(n));
    a_hard_bit = t3hb(39);
    a_llr = t3llr(39);
    @(negedge clk);
    chk("bp_rdy_low0", 64'(a_rd_rdy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rdy_low1", 64'(a_rd_rdy), 64'd0);
    @(posedge clk); #1;
    chk("bp_accepts39", 64'(acc_cnt - abase), 64'd39);
    a_grp_rdy = 1;
    @(posedge clk); #1;
    a_grp_rdy = 0;
    @(negedge clk);
    chk("bp_rdy_after_pop", 64'(a_rd_rdy), 64'd1);
    @(posedge clk); #1;
    a_rd_vld = 0;
    chk("bp_accepts40", 64'(acc_cnt - abase), 64'd40);
    a_grp_rdy = 1;
    repeat (8) @(posedge clk);
    #1;
    a_grp_rdy = 0;
    chk("bp_pops", 64'(pops - pbase), 64'd5);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Frame end on the 3-group instance
    do_reset();
    b_start = 1;
    @(posedge clk); #1;
    b_start = 0;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      b_rd_vld = 1;
      b_hard_bit = b_bytes[i/8][i%8];
      b_llr = 8'(8'h80 + i);
      @(negedge clk);
      if (b_rd_rdy) k++;
      @(posedge clk); #1;
    end
    chk("fe_accepts24", 64'(k), 64'd24);
    @(negedge clk);
    chk("fe_25th_refused", 64'(b_rd_rdy), 64'd0);
    @(posedge clk); #1;
    b_rd_vld = 0;
    b_grp_rdy = 1;
    k = 0;
    for (int t = 0; t < 40 && k < 3; t++) begin
      @(negedge clk);
      if (b_grp_vld) begin
        lv = '0;
        for (int j = 0; j < 8; j++) lv[j*8 +: 8] = 8'(8'h80 + k*8 + j);
        chk("fe_hb", 64'(b_hb_byte), 64'(b_bytes[k]));
        chk("fe_llr", b_llr_vec, lv);
        chk("fe_done_early", 64'(b_frame_done), 64'd0);
        k++;
      end
    end
    chk("fe_groups_seen", 64'(k), 64'd3);
    @(negedge clk);
    chk("fe_done_pulse", 64'(b_frame_done), 64'd1);
    chk("fe_grp_cnt", 64'(b_grp_cnt), 64'd3);
    @(negedge clk);
    chk("fe_done_cleared", 64'(b_frame_done), 64'd0);
    chk("fe_idle_rdy", 64'(b_rd_rdy), 64'd0);
    chk("fe_fifo_empty", 64'(b_grp_vld), 64'd0);
    @(posedge clk); #1;
    b_grp_rdy = 0;

    // Reset mid-group with one queued group, then a clean group
    do_reset();
    start_a();
    pbase = pops;
    for (int i = 0; i < 13; i++) send(1'b1, 8'hEE);
    a_rd_vld = 0;
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_grp_vld", 64'(a_grp_vld), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_empty", 64'(a_grp_vld), 64'd0);
    @(posedge clk); #1;
    a_grp_rdy = 1;
    start_a();
    hb = 8'h96;
    for (int j = 0; j < 8; j++) lv[j*8 +: 8] = 8'(16*j + 5);
    g.hb = hb; g.llr = lv;
    exp_q.push_back(g);
    for (int j = 0; j < 8; j++) send(hb[j], 8'(16*j + 5));
    a_rd_vld = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_pops", 64'(pops - pbase), 64'd1);
    chk("mid_rst_q_empty", 64'(exp_q.size()), 64'd0);

    // Stress: full 1000-group frame with input gaps and bursty downstream ready
    do_reset();
    start_a();
    pbase = pops;
    dbase = done_cnt;
    stress_on = 1;
    fork
      begin
        for (int gi = 0; gi < 1000 && !hung; gi++) begin
          int v;
          v = gi * 37 + 11;
          g.hb = v[7:0];
          g.llr = {$urandom, $urandom};
          exp_q.push_back(g);
          for (int j = 0; j < 8 && !hung; j++) begin
            if ($urandom_range(0, 3) == 0) begin
              a_rd_vld = 0;
              @(posedge clk); #1;
            end
            send(g.hb[j], g.llr[j*8 +: 8]);
          end
        end
        a_rd_vld = 0;
        for (int t = 0; t < 20000 && (pops - pbase) < 1000; t++) begin
          @(posedge clk); #1;
        end
        stress_on = 0;
      end
      begin
        while (stress_on) begin
          int off;
          a_grp_rdy = 1;
          for (int c = 0; c < 128 && stress_on; c++) begin
            @(posedge clk); #1;
          end
          a_grp_rdy = 0;
          off = $urandom_range(0, 512);
          for (int c = 0; c < off && stress_on; c++) begin
            @(posedge clk); #1;
          end
        end
      end
    join
    a_grp_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("stress_pops", 64'(pops - pbase), 64'd1000);
    chk("stress_q_empty", 64'(exp_q.size()), 64'd0);
    chk("stress_done_pulses", 64'(done_cnt - dbase), 64'd1);
    chk("stress_grp_cnt", 64'(a_grp_cnt), 64'd1000);
    @(negedge clk);
    chk("stress_idle_rdy", 64'(a_rd_rdy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
